// File: rtl/cpu_run_pkg.sv
// Shared types for the core run controller: FSM states, halt verdicts and the tohost pass value.
package cpu_run_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    HALT
  } run_state_e;

  typedef enum logic [2:0] {
    ST_RUNNING = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_LOOP    = 3'd3,
    ST_TIMEOUT = 3'd4
  } run_status_e;

  localparam int TOHOST_PASS_VAL = 1;

endpackage

// File: rtl/pc_trace_ring.sv
// Ring buffer of the most recently retired PCs; read index 0 is the newest entry.
module pc_trace_ring #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [XLEN-1:0]          din,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [XLEN-1:0]          dout,
  output logic                     valid
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int NUM_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  mem [DEPTH];
  logic [IDX_W-1:0] wr_ptr;
  logic [NUM_W-1:0] num_entries;
  logic [IDX_W-1:0] rd_addr;

  // DEPTH is a power of two, so the pointer wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      num_entries <= '0;
    end else if (we) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (num_entries != NUM_W'(DEPTH)) num_entries <= num_entries + 1'b1;
    end
  end

  // NOTE: storage is not reset; num_entries gates every read, so stale words never reach dout.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= din;
  end

  assign rd_addr = wr_ptr - IDX_W'(1) - rd_idx;
  assign valid   = NUM_W'(rd_idx) < num_entries;
  assign dout    = valid ? mem[rd_addr] : '0;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: sequences core reset, counts RUN cycles, detects end of test
// (tohost store, PC self-loop, watchdog) and latches a sticky verdict.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              RST_CYCLES  = 2,
  parameter int              MAX_CYCLES  = 50,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h0000_0FFC,
  parameter int              STALL_LIMIT = 4,
  parameter int              TRACE_DEPTH = 8,
  parameter int              CNT_W       = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  output logic                           core_rst_n,
  input  logic [XLEN-1:0]                pc_i,
  input  logic                           mem_we_i,
  input  logic [XLEN-1:0]                mem_addr_i,
  input  logic [XLEN-1:0]                mem_wdata_i,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx_i,
  output logic [XLEN-1:0]                trace_pc_o,
  output logic                           trace_valid_o,
  output logic                           running_o,
  output logic                           halted_o,
  output logic [2:0]                     status_o,
  output logic [XLEN-2:0]                fail_code_o,
  output logic [CNT_W-1:0]               cycle_cnt_o
);

  localparam int HOLD_W = $clog2(RST_CYCLES + 1);
  localparam int LOOP_W = $clog2(STALL_LIMIT + 1);

  run_state_e        state, next_state;
  run_status_e       status_q, halt_status;
  logic [HOLD_W-1:0] hold_cnt;
  logic [LOOP_W-1:0] loop_cnt;
  logic [XLEN-1:0]   pc_q;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [XLEN-2:0]   fail_code_q;
  logic              core_rst_q;

  logic first_run, pc_repeat, tohost_hit, loop_hit, timeout_hit;

  // cycle_cnt only advances in RUN, so zero marks the first RUN cycle (pc_q is stale there).
  assign first_run   = (cycle_cnt == '0);
  assign pc_repeat   = (pc_i == pc_q) && !first_run;
  assign tohost_hit  = mem_we_i && (mem_addr_i == TOHOST_ADDR);
  assign loop_hit    = pc_repeat && (loop_cnt == LOOP_W'(STALL_LIMIT - 1));
  assign timeout_hit = (cycle_cnt == CNT_W'(MAX_CYCLES - 1));

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    next_state  = state;
    halt_status = ST_RUNNING;
    case (state)
      HOLD: if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) next_state = RUN;
      RUN: begin
        if (tohost_hit)
          halt_status = (mem_wdata_i == XLEN'(TOHOST_PASS_VAL)) ? ST_PASS : ST_FAIL;
        else if (loop_hit)
          halt_status = ST_LOOP;
        else if (timeout_hit)
          halt_status = ST_TIMEOUT;
        if (halt_status != ST_RUNNING) next_state = HALT;
      end
      default: next_state = state;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= HOLD;
    else        state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_rst_q  <= 1'b0;
      hold_cnt    <= '0;
      loop_cnt    <= '0;
      pc_q        <= '0;
      cycle_cnt   <= '0;
      status_q    <= ST_RUNNING;
      fail_code_q <= '0;
    end else begin
      core_rst_q <= (next_state != HOLD);
      case (state)
        HOLD: hold_cnt <= hold_cnt + 1'b1;
        RUN: begin
          if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
          pc_q     <= pc_i;
          loop_cnt <= pc_repeat ? loop_cnt + 1'b1 : '0;
          if (halt_status != ST_RUNNING) status_q <= halt_status;
          if (halt_status == ST_FAIL) fail_code_q <= mem_wdata_i[XLEN-1:1];
        end
        default: ;
      endcase
    end
  end

  pc_trace_ring #(
    .XLEN  (XLEN),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (state == RUN),
    .din    (pc_i),
    .rd_idx (trace_idx_i),
    .dout   (trace_pc_o),
    .valid  (trace_valid_o)
  );

  assign core_rst_n  = core_rst_q;
  assign running_o   = (state == RUN);
  assign halted_o    = (state == HALT);
  assign status_o    = status_q;
  assign fail_code_o = fail_code_q;
  assign cycle_cnt_o = cycle_cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed-plus-random bench for cpu_run_ctrl against an edge-level behavioural model.
module tb_cpu_run_ctrl;

  localparam int          RST_CYCLES  = 2;
  localparam int          MAX_CYCLES  = 50;
  localparam int          STALL_LIMIT = 4;
  localparam int          TRACE_DEPTH = 8;
  localparam logic [31:0] TOHOST      = 32'h0000_0FFC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_rst_n;
  logic [31:0] pc = '0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [2:0]  trace_idx = '0;
  logic [31:0] trace_pc;
  logic        trace_valid;
  logic        running;
  logic        halted;
  logic [2:0]  status;
  logic [30:0] fail_code;
  logic [31:0] cycle_cnt;

  cpu_run_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .core_rst_n    (core_rst_n),
    .pc_i          (pc),
    .mem_we_i      (mem_we),
    .mem_addr_i    (mem_addr),
    .mem_wdata_i   (mem_wdata),
    .trace_idx_i   (trace_idx),
    .trace_pc_o    (trace_pc),
    .trace_valid_o (trace_valid),
    .running_o     (running),
    .halted_o      (halted),
    .status_o      (status),
    .fail_code_o   (fail_code),
    .cycle_cnt_o   (cycle_cnt)
  );

  always #10 clk = ~clk;

  // Model: edges seen since reset release, retired-PC history, verdict.
  int          rel_edges;
  bit          m_halted;
  int          m_cycles;
  logic [31:0] hist [$];
  logic [2:0]  m_status;
  logic [30:0] m_fail;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // True when pc equals each of the previous STALL_LIMIT retired PCs.
  function automatic bit loop_seen(input logic [31:0] p);
    if (hist.size() < STALL_LIMIT) return 1'b0;
    for (int k = 1; k <= STALL_LIMIT; k++)
      if (hist[hist.size() - k] != p) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    logic [2:0] v;
    v = 3'd0;
    if (!rst_n) begin
      rel_edges = 0;
      m_halted  = 1'b0;
      m_cycles  = 0;
      hist.delete();
      m_status  = 3'd0;
      m_fail    = '0;
    end else if (rel_edges < RST_CYCLES) begin
      rel_edges++;
    end else if (!m_halted) begin
      if (mem_we && mem_addr == TOHOST) begin
        if (mem_wdata == 32'd1) v = 3'd1;
        else begin
          v = 3'd2;
          m_fail = mem_wdata[31:1];
        end
      end else if (loop_seen(pc)) v = 3'd3;
      else if (m_cycles == MAX_CYCLES - 1) v = 3'd4;
      m_cycles++;
      hist.push_back(pc);
      if (v != 3'd0) begin
        m_status = v;
        m_halted = 1'b1;
      end
    end
  endtask

  task automatic check_outputs(input string ph);
    check({ph, "_core_rst_n"}, core_rst_n, rel_edges >= RST_CYCLES);
    check({ph, "_running"}, running, (rel_edges >= RST_CYCLES) && !m_halted);
    check({ph, "_halted"}, halted, m_halted);
    check({ph, "_status"}, status, m_status);
    check({ph, "_fail_code"}, fail_code, m_fail);
    check({ph, "_cycle_cnt"}, cycle_cnt, m_cycles);
  endtask

  task automatic step(input bit r, input logic [31:0] p, input bit we,
                      input logic [31:0] a, input logic [31:0] d, input string ph);
    rst_n     = r;
    pc        = p;
    mem_we    = we;
    mem_addr  = a;
    mem_wdata = d;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(ph);
  endtask

  // Ordinary run cycle with a random store that never targets tohost.
  task automatic run_step(input logic [31:0] p, input string ph);
    logic [31:0] a;
    a = $urandom;
    if (a == TOHOST) a = a ^ 32'h4;
    step(1'b1, p, 1'($urandom), a, $urandom, ph);
  endtask

  task automatic do_reset(input int n, input string ph);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b0, '0, '0, ph);
    for (int i = 0; i < RST_CYCLES; i++) step(1'b1, $urandom, 1'b0, '0, '0, ph);
  endtask

  task automatic trace_sweep(input string ph);
    int n;
    logic [31:0] exp_pc;
    n = (hist.size() < TRACE_DEPTH) ? hist.size() : TRACE_DEPTH;
    for (int i = 0; i < TRACE_DEPTH; i++) begin
      trace_idx = 3'(i);
      #1;
      exp_pc = (i < n) ? hist[hist.size() - 1 - i] : 32'd0;
      check($sformatf("%s_trace_valid%0d", ph, i), trace_valid, i < n);
      check($sformatf("%s_trace_pc%0d", ph, i), trace_pc, exp_pc);
    end
  endtask

  initial begin
    logic [31:0] p;
    logic [31:0] d;

    // 1. Reset held 3 cycles, then core released after RST_CYCLES edges.
    for (int i = 0; i < 3; i++) step(1'b0, $urandom, 1'b0, '0, '0, "t1_rst");
    check("t1_status_reset", status, 3'd0);
    step(1'b1, $urandom, 1'b0, '0, '0, "t1_rel0");
    check("t1_core_still_low", core_rst_n, 1'b0);
    step(1'b1, $urandom, 1'b0, '0, '0, "t1_rel1");
    check("t1_core_released", core_rst_n, 1'b1);
    check("t1_running", running, 1'b1);

    // 2. Pass verdict; later tohost stores are ignored.
    p = $urandom & ~32'h3;
    for (int i = 0; i < 3; i++) begin p += 4; run_step(p, "t2_run"); end
    trace_sweep("t2_partial");
    for (int i = 0; i < 6; i++) begin p += 4; run_step(p, "t2_run"); end
    step(1'b1, p + 4, 1'b1, TOHOST, 32'd1, "t2_pass");
    check("t2_status_pass", status, 3'd1);
    step(1'b1, p + 8, 1'b1, TOHOST, 32'd7, "t2_frozen");
    for (int i = 0; i < 2; i++) run_step($urandom, "t2_frozen");
    check("t2_cycle_frozen", cycle_cnt, 32'd10);

    // 3. Failing store coinciding with a self-loop and the watchdog.
    do_reset(1, "t3_rst");
    p = $urandom & ~32'h3;
    for (int i = 0; i < 100 && m_cycles < 45; i++) begin p += 4; run_step(p, "t3_run"); end
    p += 4;
    for (int i = 0; i < 4; i++) step(1'b1, p, 1'b0, '0, '0, "t3_hold_pc");
    step(1'b1, p, 1'b1, TOHOST, 32'd7, "t3_fail");
    check("t3_status_fail", status, 3'd2);
    check("t3_fail_code", fail_code, 31'd3);

    // 4. Self-loop: 0, 4, 8, then 8 held until the loop verdict.
    do_reset(1, "t4_rst");
    step(1'b1, 32'h0, 1'b0, '0, '0, "t4_pc");
    step(1'b1, 32'h4, 1'b0, '0, '0, "t4_pc");
    for (int i = 0; i < 10 && !halted; i++) step(1'b1, 32'h8, 1'b0, '0, '0, "t4_loop");
    check("t4_halted", halted, 1'b1);
    check("t4_status_loop", status, 3'd3);
    check("t4_cycle_cnt", cycle_cnt, 32'd7);

    // 4b. Fail verdict with random write data.
    do_reset(1, "t4b_rst");
    p = $urandom & ~32'h3;
    for (int i = 0; i < 5; i++) begin p += 4; run_step(p, "t4b_run"); end
    d = $urandom;
    if (d == 32'd1) d = 32'd3;
    step(1'b1, p + 4, 1'b1, TOHOST, d, "t4b_fail");
    check("t4b_status_fail", status, 3'd2);
    check("t4b_fail_code", fail_code, d >> 1);

    // 5. Watchdog timeout with a wrapped trace.
    do_reset(2, "t5_rst");
    p = $urandom & ~32'h3;
    for (int i = 0; i < 100 && !m_halted; i++) begin p += 4; run_step(p, "t5_run"); end
    check("t5_halted", halted, 1'b1);
    check("t5_status_timeout", status, 3'd4);
    check("t5_cycle_cnt", cycle_cnt, 32'd50);
    trace_sweep("t5_wrap");
    for (int i = 0; i < 3; i++) run_step($urandom, "t5_frozen");
    trace_sweep("t5_frozen");

    // 6. One-cycle reset in the middle of a run.
    do_reset(1, "t6_rst");
    p = $urandom & ~32'h3;
    for (int i = 0; i < 100 && m_cycles < 20; i++) begin p += 4; run_step(p, "t6_run"); end
    step(1'b0, p + 4, 1'b0, '0, '0, "t6_midrst");
    check("t6_cycle_cleared", cycle_cnt, 32'd0);
    trace_sweep("t6_cleared");
    step(1'b1, $urandom, 1'b0, '0, '0, "t6_rel0");
    check("t6_core_low", core_rst_n, 1'b0);
    step(1'b1, $urandom, 1'b0, '0, '0, "t6_rel1");
    check("t6_core_high", core_rst_n, 1'b1);
    for (int i = 0; i < 3; i++) begin p += 4; run_step(p, "t6_rerun"); end
    trace_sweep("t6_rerun");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
